// File: rtl/issue_pkg.sv
// Shared field layout, default widths and instruction decode for the scoreboarded issue control.
package issue_pkg;
  localparam int INSTR_WIDTH_D     = 32;
  localparam int ADDR_WIDTH_D      = 5;
  localparam int OPER_WIDTH_D      = 2;
  localparam int MAX_OUTSTANDING_D = 4;

  localparam int OPER_MSB = 31;
  localparam int DEST_MSB = 29;
  localparam int SRC0_MSB = 24;
  localparam int SRC1_MSB = 19;

  typedef struct packed {
    logic [OPER_WIDTH_D-1:0] oper;
    logic [ADDR_WIDTH_D-1:0] dest;
    logic [ADDR_WIDTH_D-1:0] src0;
    logic [ADDR_WIDTH_D-1:0] src1;
  } instr_f_t;

  function automatic instr_f_t decode_fields(input logic [INSTR_WIDTH_D-1:0] instr);
    instr_f_t f;
    f.oper = instr[OPER_MSB -: OPER_WIDTH_D];
    f.dest = instr[DEST_MSB -: ADDR_WIDTH_D];
    f.src0 = instr[SRC0_MSB -: ADDR_WIDTH_D];
    f.src1 = instr[SRC1_MSB -: ADDR_WIDTH_D];
    return f;
  endfunction
endpackage

// File: rtl/issue_ctrl_sb_if.sv
// Instruction/ALU/writeback bundle between the issue control and its neighbours.
interface issue_ctrl_sb_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int OPER_WIDTH  = 2,
  parameter int CNT_WIDTH   = 3
);
  logic [INSTR_WIDTH-1:0] i_instr;
  logic                   i_valid;
  logic                   o_ready;
  logic [ADDR_WIDTH-1:0]  o_reg0_addr;
  logic [ADDR_WIDTH-1:0]  o_reg1_addr;
  logic [ADDR_WIDTH-1:0]  o_reg2_addr;
  logic [OPER_WIDTH-1:0]  o_alu_oper;
  logic                   o_alu_valid;
  logic                   i_alu_ready;
  logic                   i_wb_valid;
  logic [ADDR_WIDTH-1:0]  i_wb_addr;
  logic                   i_drain;
  logic                   o_idle;
  logic [CNT_WIDTH-1:0]   o_outstanding;
  logic                   o_wb_err;

  modport slave (
    input  i_instr, i_valid, i_alu_ready, i_wb_valid, i_wb_addr, i_drain,
    output o_ready, o_reg0_addr, o_reg1_addr, o_reg2_addr, o_alu_oper, o_alu_valid,
           o_idle, o_outstanding, o_wb_err
  );
  modport master (
    output i_instr, i_valid, i_alu_ready, i_wb_valid, i_wb_addr, i_drain,
    input  o_ready, o_reg0_addr, o_reg1_addr, o_reg2_addr, o_alu_oper, o_alu_valid,
           o_idle, o_outstanding, o_wb_err
  );
endinterface

// File: rtl/issue_ctrl_sb_scoreboard.sv
// Pending-register bit vector: one set port (issue), one clear port (writeback), four read ports.
module issue_ctrl_sb_scoreboard #(
  parameter int ADDR_WIDTH = 5
)(
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic [ADDR_WIDTH-1:0] rdd_addr,
  input  logic [ADDR_WIDTH-1:0] rdw_addr,
  output logic                  rd0_pend,
  output logic                  rd1_pend,
  output logic                  rdd_pend,
  output logic                  rdw_pend
);
  localparam int ENTRIES = 2**ADDR_WIDTH;

  logic [ENTRIES-1:0] pend;

  // Register 0 is never marked pending, so it can never cause a hazard.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      pend <= '0;
    end else begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      if (set_en && set_addr != '0) pend[set_addr] <= 1'b1;
    end
  end

  assign rd0_pend = pend[rd0_addr];
  assign rd1_pend = pend[rd1_addr];
  assign rdd_pend = pend[rdd_addr];
  assign rdw_pend = pend[rdw_addr];
endmodule

// File: rtl/issue_ctrl_sb.sv
// Scoreboarded ALU issue control: up to MAX_OUTSTANDING in-flight results, RAW/WAW stall, drain/idle.
module issue_ctrl_sb
  import issue_pkg::*;
#(
  parameter int INSTR_WIDTH     = INSTR_WIDTH_D,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_D,
  parameter int OPER_WIDTH      = OPER_WIDTH_D,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_D,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
)(
  input  logic           i_CLK,
  input  logic           i_RSTn,
  issue_ctrl_sb_if.slave bus
);
  instr_f_t               f;
  logic                   p_src0, p_src1, p_dest, p_wb;
  logic                   hazard, slot_free, ready, accept, wb_hit, wb_dec;
  logic [CNT_WIDTH-1:0]   count;
  logic                   alu_valid, wb_err;
  logic [OPER_WIDTH-1:0]  alu_oper;
  logic [ADDR_WIDTH-1:0]  reg2;

  assign f = decode_fields(bus.i_instr);

  issue_ctrl_sb_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .i_CLK    (i_CLK),
    .i_RSTn   (i_RSTn),
    .set_en   (accept),
    .set_addr (f.dest),
    .clr_en   (wb_hit),
    .clr_addr (bus.i_wb_addr),
    .rd0_addr (f.src0),
    .rd1_addr (f.src1),
    .rdd_addr (f.dest),
    .rdw_addr (bus.i_wb_addr),
    .rd0_pend (p_src0),
    .rd1_pend (p_src1),
    .rdd_pend (p_dest),
    .rdw_pend (p_wb)
  );

  assign hazard    = p_src0 | p_src1 | p_dest;
  assign slot_free = !alu_valid || bus.i_alu_ready;
  assign ready     = i_RSTn && !bus.i_drain && !hazard && slot_free
                     && (count < CNT_WIDTH'(MAX_OUTSTANDING));
  assign accept    = bus.i_valid && ready;

  // Untracked r0 results are retired by a r0 writeback; the count guard keeps it from underflowing.
  assign wb_hit = bus.i_wb_valid && (p_wb || (bus.i_wb_addr == '0 && count != '0));
  assign wb_dec = wb_hit && count != '0;

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      count     <= '0;
      alu_valid <= 1'b0;
      alu_oper  <= '0;
      reg2      <= '0;
      wb_err    <= 1'b0;
    end else begin
      wb_err <= bus.i_wb_valid && !wb_hit;
      case ({accept, wb_dec})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      if (accept) begin
        alu_valid <= 1'b1;
        alu_oper  <= f.oper;
        reg2      <= f.dest;
      end else if (bus.i_alu_ready) begin
        alu_valid <= 1'b0;
      end
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_reg0_addr   = f.src0;
  assign bus.o_reg1_addr   = f.src1;
  assign bus.o_reg2_addr   = reg2;
  assign bus.o_alu_oper    = alu_oper;
  assign bus.o_alu_valid   = alu_valid;
  assign bus.o_idle        = (count == '0) && !alu_valid;
  assign bus.o_outstanding = count;
  assign bus.o_wb_err      = wb_err;
endmodule

// File: tb/tb_issue_ctrl_sb.sv
// Directed plus randomized bench for issue_ctrl_sb against a cycle-level reference model.
module tb_issue_ctrl_sb;
  localparam int MAXO = 4;

  logic i_CLK = 1'b0;
  logic i_RSTn;
  int   n_tests = 0;
  int   n_fail  = 0;

  issue_ctrl_sb_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(5), .OPER_WIDTH(2), .CNT_WIDTH(3)) bus ();

  issue_ctrl_sb #(.INSTR_WIDTH(32), .ADDR_WIDTH(5), .OPER_WIDTH(2), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(3))
    dut (.i_CLK(i_CLK), .i_RSTn(i_RSTn), .bus(bus));

  always #5 i_CLK = ~i_CLK;

  // reference state: pending registers, in-flight count, ALU output slot
  bit       pend_m [32];
  int       cnt_m;
  bit       av_m, err_m, last_rdy;
  bit [1:0] op_m;
  bit [4:0] rd_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int o, input int d, input int s0, input int s1);
    logic [31:0] w;
    w = '0;
    w[31:30] = 2'(o);
    w[29:25] = 5'(d);
    w[24:20] = 5'(s0);
    w[19:15] = 5'(s1);
    return w;
  endfunction

  task automatic step(input bit rst_n, input bit v, input logic [31:0] ins, input bit ar,
                      input bit wv, input logic [4:0] wa, input bit dr);
    bit hz, rdy, acc, hit;
    logic [1:0] o;
    logic [4:0] d, s0, s1;
    i_RSTn = rst_n; bus.i_valid = v; bus.i_instr = ins; bus.i_alu_ready = ar;
    bus.i_wb_valid = wv; bus.i_wb_addr = wa; bus.i_drain = dr;
    o = ins[31:30]; d = ins[29:25]; s0 = ins[24:20]; s1 = ins[19:15];
    hz  = pend_m[s0] | pend_m[s1] | pend_m[d];
    rdy = rst_n && !dr && !hz && (!av_m || ar) && (cnt_m < MAXO);
    #1;
    chk("ready", bus.o_ready, rdy);
    chk("reg0", bus.o_reg0_addr, s0);
    chk("reg1", bus.o_reg1_addr, s1);
    last_rdy = rdy;
    @(posedge i_CLK);
    if (!rst_n) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      cnt_m = 0; av_m = 0; op_m = 0; rd_m = 0; err_m = 0;
    end else begin
      acc   = v && rdy;
      hit   = wv && (pend_m[wa] || (wa == 0 && cnt_m > 0));
      err_m = wv && !hit;
      if (hit) begin
        pend_m[wa] = 1'b0;
        if (cnt_m > 0) cnt_m--;
      end
      if (acc) begin
        if (d != 0) pend_m[d] = 1'b1;
        cnt_m++; av_m = 1; op_m = o; rd_m = d;
      end else if (ar) begin
        av_m = 0;
      end
    end
    @(negedge i_CLK);
    chk("alu_valid", bus.o_alu_valid, av_m);
    chk("alu_oper", bus.o_alu_oper, op_m);
    chk("reg2", bus.o_reg2_addr, rd_m);
    chk("outstanding", bus.o_outstanding, cnt_m);
    chk("idle", bus.o_idle, (cnt_m == 0 && !av_m));
    chk("wb_err", bus.o_wb_err, err_m);
  endtask

  task automatic idle_step(input bit wv, input logic [4:0] wa);
    step(1, 0, '0, 1, wv, wa, 0);
  endtask

  initial begin
    bit       v, ar, wv, dr, rs;
    logic [4:0] wa;
    int       pq [$];
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    cnt_m = 0; av_m = 0; op_m = 0; rd_m = 0; err_m = 0;

    // 1: reset with valid high, then first issue
    repeat (3) step(0, 1, mk(2, 5, 1, 2), 1, 0, 0, 0);
    chk("t1_rst_valid", bus.o_alu_valid, 0);
    chk("t1_rst_cnt", bus.o_outstanding, 0);
    step(1, 1, mk(2, 5, 1, 2), 1, 0, 0, 0);
    chk("t1_rdy", last_rdy, 1);
    chk("t1_valid", bus.o_alu_valid, 1);
    chk("t1_oper", bus.o_alu_oper, 2);
    chk("t1_reg2", bus.o_reg2_addr, 5);

    // 2: RAW on r5, no writeback bypass
    repeat (2) step(1, 1, mk(1, 6, 5, 0), 1, 0, 0, 0);
    chk("t2_stall", last_rdy, 0);
    step(1, 1, mk(1, 6, 5, 0), 1, 1, 5, 0);
    chk("t2_no_bypass", last_rdy, 0);
    step(1, 1, mk(1, 6, 5, 0), 1, 0, 0, 0);
    chk("t2_after_wb", last_rdy, 1);
    idle_step(1, 6);

    // 3: fill to MAX_OUTSTANDING, fifth stalls until a writeback
    for (int r = 1; r <= 4; r++) step(1, 1, mk(3, r, 0, 0), 1, 0, 0, 0);
    step(1, 1, mk(0, 8, 0, 0), 1, 0, 0, 0);
    chk("t3_full_rdy", last_rdy, 0);
    chk("t3_full_cnt", bus.o_outstanding, 4);
    step(1, 1, mk(0, 8, 0, 0), 1, 1, 2, 0);
    chk("t3_wb_same_cycle", last_rdy, 0);
    step(1, 1, mk(0, 8, 0, 0), 1, 0, 0, 0);
    chk("t3_fifth", last_rdy, 1);
    idle_step(1, 1); idle_step(1, 3); idle_step(1, 4); idle_step(1, 8);

    // 4: ALU backpressure holds the op
    step(1, 1, mk(1, 9, 0, 0), 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, mk(2, 10, 0, 0), 0, 0, 0, 0);
      chk("t4_hold_rdy", last_rdy, 0);
      chk("t4_hold_oper", bus.o_alu_oper, 1);
      chk("t4_hold_reg2", bus.o_reg2_addr, 9);
    end
    step(1, 1, mk(2, 10, 0, 0), 1, 0, 0, 0);
    chk("t4_release", last_rdy, 1);
    chk("t4_new_reg2", bus.o_reg2_addr, 10);
    idle_step(1, 9); idle_step(1, 10);

    // 5: bad writeback, then accept with concurrent writeback
    idle_step(1, 7);
    chk("t5_err", bus.o_wb_err, 1);
    chk("t5_cnt", bus.o_outstanding, 0);
    idle_step(0, 0);
    chk("t5_err_pulse", bus.o_wb_err, 0);
    step(1, 1, mk(0, 11, 0, 0), 1, 0, 0, 0);
    step(1, 1, mk(0, 12, 0, 0), 1, 1, 11, 0);
    chk("t5_acc_wb_cnt", bus.o_outstanding, 1);
    idle_step(1, 12);

    // 6: drain, idle, reset mid-flight
    step(1, 1, mk(1, 13, 0, 0), 1, 0, 0, 0);
    step(1, 1, mk(1, 14, 0, 0), 1, 0, 0, 0);
    step(1, 1, mk(1, 15, 0, 0), 1, 0, 0, 1);
    chk("t6_drain", last_rdy, 0);
    step(1, 1, mk(1, 15, 0, 0), 1, 1, 13, 1);
    step(1, 1, mk(1, 15, 0, 0), 1, 1, 14, 1);
    chk("t6_cnt0", bus.o_outstanding, 0);
    chk("t6_idle", bus.o_idle, 1);
    step(1, 1, mk(1, 15, 0, 0), 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    chk("t6_rst_cnt", bus.o_outstanding, 0);
    chk("t6_rst_valid", bus.o_alu_valid, 0);
    idle_step(1, 15);
    chk("t6_late_wb_err", bus.o_wb_err, 1);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom % 4) != 0;
      ar = ($urandom % 3) != 0;
      wv = ($urandom % 2) != 0;
      dr = ($urandom % 10) == 0;
      rs = ($urandom % 80) != 0;
      pq.delete();
      for (int r = 1; r < 32; r++) if (pend_m[r]) pq.push_back(r);
      if (pq.size() > 0 && ($urandom % 5) != 0) wa = 5'(pq[$urandom % pq.size()]);
      else wa = 5'($urandom % 8);
      step(rs, v, mk($urandom % 4, $urandom % 8, $urandom % 8, $urandom % 8), ar, wv, wa, dr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
